// File: rtl/relay_station_credit_if.sv
// Stream link between a sender, a credit-based relay station and a receiver.
// Handshake: sender pushes when if_write & if_write_ce & if_full_n; receiver pops when if_read & if_read_ce & if_empty_n.
interface relay_station_credit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 3
);
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic [CNT_WIDTH-1:0]  if_credit;
  logic [CNT_WIDTH-1:0]  if_count;

  // Drives the write and read requests; observes status and data.
  modport master (
    input  if_full_n, if_empty_n, if_dout, if_credit, if_count,
    output if_write_ce, if_write, if_din, if_read_ce, if_read
  );

  // The relay station itself.
  modport slave (
    output if_full_n, if_empty_n, if_dout, if_credit, if_count,
    input  if_write_ce, if_write, if_din, if_read_ce, if_read
  );
endinterface

// File: rtl/relay_station_credit.sv
// Credit-based relay station: LEVEL forward stages into a FWFT FIFO, LEVEL credit-return
// stages back to a sender credit counter. CONNECT=0 builds a tied-off stub.
module relay_station_credit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 6,
  parameter int LEVEL      = 2,
  parameter int CONNECT    = 1,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  relay_station_credit_if.slave  link
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  generate
    if (CONNECT == 0) begin : g_stub
      assign link.if_full_n  = 1'b0;
      assign link.if_empty_n = 1'b0;
      assign link.if_dout    = '0;
      assign link.if_credit  = '0;
      assign link.if_count   = '0;
    end else begin : g_link
      logic                  push;
      logic                  pop;
      logic                  fifo_wr;
      logic [DATA_WIDTH-1:0] fifo_wdata;
      logic                  ret;
      logic [CNT_WIDTH-1:0]  credit;
      logic [CNT_WIDTH-1:0]  credit_next;
      logic                  full_n;
      logic [CNT_WIDTH-1:0]  count;
      logic                  empty_n;
      logic [PTR_W-1:0]      wr_ptr;
      logic [PTR_W-1:0]      rd_ptr;
      logic [DATA_WIDTH-1:0] mem [DEPTH];

      assign push    = link.if_write & link.if_write_ce & full_n;
      assign empty_n = (count != '0);
      assign pop     = link.if_read & link.if_read_ce & empty_n;

      if (LEVEL == 0) begin : g_direct
        assign fifo_wr    = push;
        assign fifo_wdata = link.if_din;
        assign ret        = pop;
      end else begin : g_pipe
        logic [LEVEL-1:0]      fwd_vld;
        logic [LEVEL-1:0]      ret_vld;
        logic [DATA_WIDTH-1:0] fwd_data [LEVEL];

        // Both pipes free-run; a reset drops every in-flight word and credit.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            fwd_vld <= '0;
            ret_vld <= '0;
          end else begin
            fwd_vld[0] <= push;
            ret_vld[0] <= pop;
            for (int i = 1; i < LEVEL; i++) begin
              fwd_vld[i] <= fwd_vld[i-1];
              ret_vld[i] <= ret_vld[i-1];
            end
          end
        end

        always_ff @(posedge clk) begin
          fwd_data[0] <= link.if_din;
          for (int i = 1; i < LEVEL; i++) begin
            fwd_data[i] <= fwd_data[i-1];
          end
        end

        assign fifo_wr    = fwd_vld[LEVEL-1];
        assign fifo_wdata = fwd_data[LEVEL-1];
        assign ret        = ret_vld[LEVEL-1];
      end

      always_comb begin
        credit_next = credit - CNT_WIDTH'(push) + CNT_WIDTH'(ret);
      end

      // full_n is registered from the next credit value so it is a clean flop output.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          credit <= CNT_WIDTH'(DEPTH);
          full_n <= 1'b1;
        end else begin
          credit <= credit_next;
          full_n <= (credit_next != '0);
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (fifo_wr) begin
            wr_ptr <= ptr_inc(wr_ptr);
          end
          if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
          end
          count <= count + CNT_WIDTH'(fifo_wr) - CNT_WIDTH'(pop);
        end
      end

      always_ff @(posedge clk) begin
        if (fifo_wr) begin
          mem[wr_ptr] <= fifo_wdata;
        end
      end

      assign link.if_full_n  = full_n;
      assign link.if_empty_n = empty_n;
      assign link.if_dout    = empty_n ? mem[rd_ptr] : '0;
      assign link.if_credit  = credit;
      assign link.if_count   = count;
    end
  endgenerate

endmodule

// File: tb/tb_relay_station_credit.sv
// Bench for relay_station_credit: LEVEL=2/DEPTH=6 main build, LEVEL=0/DEPTH=2 build
// and a CONNECT=0 stub, driven by a vector table plus hand-written sequences.
module tb_relay_station_credit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  relay_station_credit_if #(.DATA_WIDTH(32), .CNT_WIDTH(3)) rs ();
  relay_station_credit_if #(.DATA_WIDTH(32), .CNT_WIDTH(2)) rz ();
  relay_station_credit_if #(.DATA_WIDTH(32), .CNT_WIDTH(3)) rx ();

  relay_station_credit #(.DATA_WIDTH(32), .DEPTH(6), .LEVEL(2), .CONNECT(1)) dut_main (
    .clk(clk), .reset(reset), .link(rs.slave)
  );
  relay_station_credit #(.DATA_WIDTH(32), .DEPTH(2), .LEVEL(0), .CONNECT(1)) dut_l0 (
    .clk(clk), .reset(reset), .link(rz.slave)
  );
  relay_station_credit #(.DATA_WIDTH(32), .DEPTH(6), .LEVEL(2), .CONNECT(0)) dut_stub (
    .clk(clk), .reset(reset), .link(rx.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic        wce;
    logic [31:0] din;
    logic        rd;
    logic        rce;
    logic        full_n;
    logic        empty_n;
    logic        chk_dout;
    logic [31:0] dout;
    logic [2:0]  credit;
    logic [2:0]  count;
  } vec_t;

  vec_t        vt [23];
  logic [31:0] exp_q [$];
  logic [31:0] zq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_rs(input logic wr, input logic wce, input logic [31:0] din,
                          input logic rd, input logic rce);
    rs.if_write    = wr;
    rs.if_write_ce = wce;
    rs.if_din      = din;
    rs.if_read     = rd;
    rs.if_read_ce  = rce;
  endtask

  task automatic drive_rz(input logic wr, input logic wce, input logic [31:0] din,
                          input logic rd, input logic rce);
    rz.if_write    = wr;
    rz.if_write_ce = wce;
    rz.if_din      = din;
    rz.if_read     = rd;
    rz.if_read_ce  = rce;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, got, first_out, last_out, accepted, six_cyc, seen, cyc;
    logic m_push, m_pop;
    logic [2:0] m_credit;
    logic [1:0] zc, zn;
    logic [31:0] w;

    total = 0;
    bad   = 0;
    // cycle 0 idle, push A5 at 1 (visible 4, credit back at 7), ce-gated writes 7..11,
    // two words with sink stalled, read_ce gating 16..17, then drain.
    vt[0]  = '{0, 0, 32'h0,  1, 1, 1, 0, 0, 32'h0,  3'd6, 3'd0};
    vt[1]  = '{1, 1, 32'hA5, 1, 1, 1, 0, 0, 32'h0,  3'd6, 3'd0};
    vt[2]  = '{0, 0, 32'h0,  1, 1, 1, 0, 0, 32'h0,  3'd5, 3'd0};
    vt[3]  = '{0, 0, 32'h0,  1, 1, 1, 0, 0, 32'h0,  3'd5, 3'd0};
    vt[4]  = '{0, 0, 32'h0,  1, 1, 1, 1, 1, 32'hA5, 3'd5, 3'd1};
    vt[5]  = '{0, 0, 32'h0,  1, 1, 1, 0, 0, 32'h0,  3'd5, 3'd0};
    vt[6]  = '{0, 0, 32'h0,  1, 1, 1, 0, 0, 32'h0,  3'd5, 3'd0};
    for (int i = 7; i < 12; i++) begin
      vt[i] = '{1, 0, 32'hEE, 1, 1, 1, 0, 0, 32'h0, 3'd6, 3'd0};
    end
    vt[12] = '{1, 1, 32'h11, 0, 0, 1, 0, 0, 32'h0,  3'd6, 3'd0};
    vt[13] = '{1, 1, 32'h22, 0, 0, 1, 0, 0, 32'h0,  3'd5, 3'd0};
    vt[14] = '{0, 0, 32'h0,  0, 0, 1, 0, 0, 32'h0,  3'd4, 3'd0};
    vt[15] = '{0, 0, 32'h0,  0, 0, 1, 1, 1, 32'h11, 3'd4, 3'd1};
    vt[16] = '{0, 0, 32'h0,  1, 0, 1, 1, 1, 32'h11, 3'd4, 3'd2};
    vt[17] = '{0, 0, 32'h0,  1, 0, 1, 1, 1, 32'h11, 3'd4, 3'd2};
    vt[18] = '{0, 0, 32'h0,  1, 1, 1, 1, 1, 32'h11, 3'd4, 3'd2};
    vt[19] = '{0, 0, 32'h0,  1, 1, 1, 1, 1, 32'h22, 3'd4, 3'd1};
    vt[20] = '{0, 0, 32'h0,  1, 1, 1, 0, 0, 32'h0,  3'd4, 3'd0};
    vt[21] = '{0, 0, 32'h0,  1, 1, 1, 0, 0, 32'h0,  3'd5, 3'd0};
    vt[22] = '{0, 0, 32'h0,  1, 1, 1, 0, 0, 32'h0,  3'd6, 3'd0};

    reset = 1'b1;
    drive_rs(0, 0, 0, 0, 0);
    drive_rz(0, 0, 0, 0, 0);
    rx.if_write = 1'b0; rx.if_write_ce = 1'b0; rx.if_din = '0;
    rx.if_read  = 1'b0; rx.if_read_ce  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // vector table on the main build
    for (int i = 0; i < 23; i++) begin
      drive_rs(vt[i].wr, vt[i].wce, vt[i].din, vt[i].rd, vt[i].rce);
      @(negedge clk);
      chk($sformatf("v%0d full_n", i),  {31'b0, rs.if_full_n},  {31'b0, vt[i].full_n});
      chk($sformatf("v%0d empty_n", i), {31'b0, rs.if_empty_n}, {31'b0, vt[i].empty_n});
      chk($sformatf("v%0d credit", i),  {29'b0, rs.if_credit},  {29'b0, vt[i].credit});
      chk($sformatf("v%0d count", i),   {29'b0, rs.if_count},   {29'b0, vt[i].count});
      if (vt[i].chk_dout) chk($sformatf("v%0d dout", i), rs.if_dout, vt[i].dout);
      next_cycle();
    end

    // 100 back-to-back words, sink always reading
    sent = 0; got = 0; first_out = -1; last_out = -1; cyc = 0;
    while (got < 100 && cyc < 400) begin
      drive_rs(sent < 100, 1, 32'h1000 + sent, 1, 1);
      @(negedge clk);
      if (sent > 0 && sent < 100) chk("t2 full_n held", {31'b0, rs.if_full_n}, 32'd1);
      if (rs.if_empty_n) begin
        if (exp_q.size() == 0) chk("t2 unexpected word", rs.if_dout, 32'hFFFF_FFFF);
        else chk("t2 order", rs.if_dout, exp_q.pop_front());
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      if (sent < 100 && rs.if_full_n) begin
        exp_q.push_back(32'h1000 + sent);
        sent++;
      end
      next_cycle();
      cyc++;
    end
    chk("t2 words received", got, 100);
    chk("t2 one per cycle span", last_out - first_out, 99);
    cyc = 0;
    drive_rs(0, 0, 0, 1, 1);
    while (rs.if_credit != 3'd6 && cyc < 20) begin
      next_cycle();
      cyc++;
    end
    chk("t2 credits home", {29'b0, rs.if_credit}, 32'd6);

    // sink stalled, push every cycle: exactly DEPTH accepted
    exp_q.delete();
    accepted = 0; six_cyc = -10;
    for (int c = 0; c < 20; c++) begin
      drive_rs(1, 1, 32'h3000 + accepted, 0, 0);
      @(negedge clk);
      if (c == six_cyc + 1) chk("t3 full_n after 6th", {31'b0, rs.if_full_n}, 32'd0);
      if (rs.if_full_n) begin
        exp_q.push_back(32'h3000 + accepted);
        accepted++;
        if (accepted == 6) six_cyc = c;
      end
      next_cycle();
    end
    drive_rs(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3 accepted", accepted, 6);
    chk("t3 count full", {29'b0, rs.if_count}, 32'd6);
    chk("t3 credit zero", {29'b0, rs.if_credit}, 32'd0);
    chk("t3 full_n low", {31'b0, rs.if_full_n}, 32'd0);
    next_cycle();
    got = 0; cyc = 0;
    while ((got < 6 || rs.if_credit != 3'd6) && cyc < 40) begin
      drive_rs(0, 0, 0, 1, 1);
      @(negedge clk);
      if (rs.if_empty_n) begin
        if (exp_q.size() == 0) chk("t3 extra word", rs.if_dout, 32'hFFFF_FFFF);
        else chk("t3 drain order", rs.if_dout, exp_q.pop_front());
        got++;
      end
      next_cycle();
      cyc++;
    end
    chk("t3 drained", got, 6);
    chk("t3 credits home", {29'b0, rs.if_credit}, 32'd6);

    // reset with 3 words stored and 2 in flight
    for (int c = 0; c < 5; c++) begin
      drive_rs(1, 1, 32'h5000 + c, 0, 0);
      next_cycle();
    end
    drive_rs(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t5 count before reset", {29'b0, rs.if_count}, 32'd3);
    chk("t5 credit before reset", {29'b0, rs.if_credit}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5 empty_n", {31'b0, rs.if_empty_n}, 32'd0);
    chk("t5 count", {29'b0, rs.if_count}, 32'd0);
    chk("t5 credit", {29'b0, rs.if_credit}, 32'd6);
    chk("t5 full_n", {31'b0, rs.if_full_n}, 32'd1);
    seen = 0;
    drive_rs(0, 0, 0, 1, 1);
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      @(negedge clk);
      if (rs.if_empty_n) seen++;
    end
    chk("t5 stale words", seen, 0);
    next_cycle();

    // LEVEL=0 build: push visible next cycle, pop returns credit on same edge
    drive_rz(1, 1, 32'h77, 0, 0);
    next_cycle();
    drive_rz(0, 0, 0, 1, 1);
    @(negedge clk);
    chk("l0 empty_n", {31'b0, rz.if_empty_n}, 32'd1);
    chk("l0 dout", rz.if_dout, 32'h77);
    chk("l0 count", {30'b0, rz.if_count}, 32'd1);
    chk("l0 credit", {30'b0, rz.if_credit}, 32'd1);
    next_cycle();
    drive_rz(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("l0 credit back", {30'b0, rz.if_credit}, 32'd2);
    chk("l0 count back", {30'b0, rz.if_count}, 32'd0);
    next_cycle();

    // LEVEL=0 random traffic against a behavioural model; stub driven alongside
    m_credit = 3'd2;
    rx.if_write = 1'b1; rx.if_write_ce = 1'b1; rx.if_din = 32'hDEAD;
    rx.if_read  = 1'b1; rx.if_read_ce  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      w = $urandom;
      drive_rz($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, w,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      @(negedge clk);
      zc = m_credit[1:0];
      zn = 2'(zq.size());
      chk("l0 rnd credit", {30'b0, rz.if_credit}, {30'b0, zc});
      chk("l0 rnd count", {30'b0, rz.if_count}, {30'b0, zn});
      chk("l0 rnd full_n", {31'b0, rz.if_full_n}, {31'b0, (m_credit != 0)});
      chk("l0 rnd empty_n", {31'b0, rz.if_empty_n}, {31'b0, (zq.size() != 0)});
      chk("l0 rnd invariant", 32'(rz.if_credit) + 32'(rz.if_count), 32'd2);
      if (zq.size() != 0) chk("l0 rnd dout", rz.if_dout, zq[0]);
      m_push = rz.if_write & rz.if_write_ce & (m_credit != 0);
      m_pop  = rz.if_read & rz.if_read_ce & (zq.size() != 0);
      if (m_pop) void'(zq.pop_front());
      if (m_push) zq.push_back(w);
      m_credit = m_credit - 3'(m_push) + 3'(m_pop);
      if (c % 100 == 0) begin
        chk("stub full_n", {31'b0, rx.if_full_n}, 32'd0);
        chk("stub empty_n", {31'b0, rx.if_empty_n}, 32'd0);
        chk("stub dout", rx.if_dout, 32'd0);
        chk("stub credit", {29'b0, rx.if_credit}, 32'd0);
        chk("stub count", {29'b0, rx.if_count}, 32'd0);
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/relay_station_credit.md
Name: relay_station_credit

Overview:
Credit-based, parametrised successor to the almost-full relay station. Data crosses LEVEL forward register stages into a receiver-side FWFT FIFO. Backpressure returns through LEVEL credit-return register stages to a sender-side credit counter, so no almost-full grace margin is needed. Used on long floorplanned stream links between kernels; adds occupancy/credit visibility and a disconnect mode.

Parameters:
DATA_WIDTH, 32, payload width in bits
DEPTH, 6, receiver FIFO entries = initial credits; must be >=1; full throughput requires DEPTH >= 2*LEVEL+2
LEVEL, 2, forward register stages and credit-return register stages (0..8)
CONNECT, 1, 0 = disconnected stub (outputs tied off, no storage)
CNT_WIDTH, $clog2(DEPTH+1), width of count/credit outputs (derived)

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
if_full_n  out  1  sender may write (credit != 0)
if_write_ce  in  1  write-side clock enable; 0 blocks acceptance
if_write  in  1  write request
if_din  in  DATA_WIDTH  write data
if_empty_n  out  1  FIFO head valid
if_read_ce  in  1  read-side clock enable; 0 blocks pop
if_read  in  1  read/pop request
if_dout  out  DATA_WIDTH  FIFO head data (FWFT)
if_credit  out  CNT_WIDTH  current sender credit count
if_count  out  CNT_WIDTH  current receiver FIFO occupancy

Behaviour:
- Reset (async assert, sync-safe deassert): credit=DEPTH, all forward/credit stage valids=0, FIFO empty. Outputs after reset: if_full_n=1, if_empty_n=0, if_dout=0, if_credit=DEPTH, if_count=0.
- push = if_write & if_write_ce & if_full_n. pop = if_read & if_read_ce & if_empty_n.
- Forward pipe free-running (no stall): push in cycle t -> FIFO entry written at end of cycle t+LEVEL -> if_empty_n/if_dout valid in cycle t+LEVEL+1. LEVEL=0: direct FIFO write, visible t+1.
- Credit return pipe free-running: pop in cycle t -> credit counter +1 at end of cycle t+LEVEL. LEVEL=0: same edge as pop.
- Credit counter: next = credit - push + ret. Simultaneous push and ret: unchanged. Never <0 or >DEPTH.
- if_full_n is a register decode of credit: 0 exactly when credit==0. A push in the cycle credit==1 makes if_full_n=0 next cycle.
- FIFO: DEPTH-entry circular buffer, wrap at DEPTH (not a power of 2 required). Simultaneous write+pop when full or empty is legal; count unchanged on simultaneous write+pop. if_dout holds last popped value's successor, or is unchanged data when empty (don't care; bench must not check).
- Invariant: credit + (forward valids in flight) + if_count + (credit-return valids in flight) == DEPTH every cycle. FIFO write when count==DEPTH is impossible by construction; verification asserts it.
- if_write_ce/if_read_ce gate only acceptance; pipelines still advance when ce=0.
- Round-trip: with DEPTH=2*LEVEL+2 and sink always reading, one push per cycle sustained indefinitely; smaller DEPTH throttles to DEPTH/(2*LEVEL+2).
- Reset mid-operation: in-flight data and credits discarded, state returns to reset values immediately.
- CONNECT=0: if_full_n=0, if_empty_n=0, if_credit=0, if_count=0, if_dout=0; no registers instantiated.

Test Plan:
1. LEVEL=2, DEPTH=6: single push 0xA5 at cycle 10, if_read=1 -> if_empty_n=1, if_dout=0xA5 in cycle 13; if_credit back to 6 at cycle 16.
2. LEVEL=2, DEPTH=6: continuous push 100 words, sink always ready -> if_full_n never deasserts after first, 100 words in order, one per cycle.
3. LEVEL=2, DEPTH=6: sink stalled, push every cycle -> exactly 6 accepted, if_full_n=0 from cycle after 6th push, if_count=6, no overflow; release sink -> 6 words in order, credits reach 6.
4. if_write=1, if_write_ce=0 for 5 cycles -> no push, if_credit stays 6; if_read_ce=0 with data present -> no pop, if_count unchanged.
5. Assert reset with 3 words in FIFO and 2 in flight -> next cycle if_empty_n=0, if_count=0, if_credit=6, if_full_n=1; no stale word ever emerges.
6. LEVEL=0, DEPTH=2 and CONNECT=0 builds: LEVEL=0 push visible next cycle, random traffic passes invariant check; CONNECT=0 all outputs 0.
